fetch_unit: RTL



---
 rtl/fetch_unit_pkg.sv | 30 +++
 rtl/fetch_unit.sv | 93 +++++++++
 2 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared ISA/fetch defines plus the fetch state type and opcode helper.
// The `define block doubles as defines.vh: WIDTH, opcodes, state encoding, opcode field position.
`ifndef FETCH_DEFINES_VH
`define FETCH_DEFINES_VH
`define WIDTH 32
`define NOP 5'd0
`define MOV 5'd1
`define ADD 5'd2
`define SUB 5'd3
`define BR 5'd4
`define HALT 5'd31
`define FETCH_RUN 1'b0
`define FETCH_HALTED 1'b1
`define FETCH_OPC_LSB (`WIDTH-5)
`endif

package fetch_unit_pkg;

  typedef enum logic {
    FETCH_RUN_S    = `FETCH_RUN,
    FETCH_HALTED_S = `FETCH_HALTED
  } fetch_state_t;

  localparam int PC_W = 32;

  function automatic logic [4:0] opcode_of(input logic [`WIDTH-1:0] w, input int lsb);
    return w[lsb +: 5];
  endfunction

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, valid/ready output register, RUN/HALTED FSM.
// Optional FETCH_PERF_CNT_EN adds fetch_count / stall_count performance counters.
//
// state   | meaning
// RUN     | fetching; loads whenever the output register is empty or being drained
// HALTED  | HALT fetched; pc parked at HALT+1 until redirect or reset
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'd0,
  parameter int          OPC_LSB  = `WIDTH-5
) (
  input  logic              clk,
  input  logic              rst,
  output logic [31:0]       pc,
  input  logic [`WIDTH-1:0] inst,
  output logic [`WIDTH-1:0] out_inst,
  output logic [31:0]       out_pc,
  output logic              out_valid,
  input  logic              out_ready,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  output logic              halted
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]       fetch_count,
  output logic [31:0]       stall_count
`endif
);

  fetch_state_t      state, state_nx;
  logic [31:0]       pc_nx, out_pc_nx;
  logic [`WIDTH-1:0] out_inst_nx;
  logic              out_valid_nx;
  logic              load;

  assign load   = (state == FETCH_RUN_S) && (!out_valid || out_ready);
  assign halted = (state == FETCH_HALTED_S);

  // Redirect beats everything, including the HALT detect of a concurrent load.
  always_comb begin
    state_nx     = state;
    pc_nx        = pc;
    out_pc_nx    = out_pc;
    out_inst_nx  = out_inst;
    out_valid_nx = out_valid;
    if (redirect_valid) begin
      pc_nx        = redirect_pc;
      out_valid_nx = 1'b0;
      state_nx     = FETCH_RUN_S;
    end else if (load) begin
      out_inst_nx  = inst;
      out_pc_nx    = pc;
      out_valid_nx = 1'b1;
      pc_nx        = pc + 32'd1;
      if (opcode_of(inst, OPC_LSB) == `HALT)
        state_nx = FETCH_HALTED_S;
    end else if (out_valid && out_ready) begin
      out_valid_nx = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= FETCH_RUN_S;
      pc        <= RESET_PC;
      out_pc    <= 32'd0;
      out_inst  <= '0;
      out_valid <= 1'b0;
    end else begin
      state     <= state_nx;
      pc        <= pc_nx;
      out_pc    <= out_pc_nx;
      out_inst  <= out_inst_nx;
      out_valid <= out_valid_nx;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_count <= 32'd0;
      stall_count <= 32'd0;
    end else begin
      if (load && !redirect_valid)
        fetch_count <= fetch_count + 32'd1;
      if (out_valid && !out_ready && !redirect_valid)
        stall_count <= stall_count + 32'd1;
    end
  end
`endif

endmodule
